// File: rtl/pux_pkg.sv
// Shared constants, FSM encoding and operand-buffer select codes for the
// pux master interface.
package pux_pkg;

    localparam int OPCW    = 8;
    localparam int DATAW   = 16;
    localparam int STATUSW = 2;
    localparam int NWORDS  = 4;
    localparam int TIMEOUT = 200;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND_OP  = 3'd1,
        ST_WAIT_RSP = 3'd2,
        ST_STREAM   = 3'd3,
        ST_WAIT_STS = 3'd4,
        ST_RESPOND  = 3'd5
    } state_t;

    localparam logic [1:0] SEL_A = 2'd0;
    localparam logic [1:0] SEL_B = 2'd1;
    localparam logic [1:0] SEL_M = 2'd2;

endpackage

// File: rtl/pux_mi_chan.sv
// One operand streamer: walks word index 0..NWORDS-1, holding valid until the
// slave's ready, and raises done after the last word.
module pux_mi_chan #(
    parameter int NWORDS = pux_pkg::NWORDS
) (
    input  logic                      axis_clk,
    input  logic                      axis_rstn,
    input  logic                      i_start,
    input  logic                      i_ready,
    output logic                      o_valid,
    output logic [$clog2(NWORDS)-1:0] o_idx,
    output logic                      o_done
);
    import pux_pkg::*;

    localparam int IW = $clog2(NWORDS);

    logic          r_valid;
    logic          r_done;
    logic [IW-1:0] r_idx;

    always_ff @(posedge axis_clk or posedge axis_rstn) begin
        if (axis_rstn) begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_idx   <= '0;
        end else if (i_start) begin
            r_valid <= 1'b1;
            r_done  <= 1'b0;
            r_idx   <= '0;
        end else if (r_valid && i_ready) begin
            if (r_idx == IW'(NWORDS - 1)) begin
                r_valid <= 1'b0;
                r_done  <= 1'b1;
            end else begin
                r_idx <= r_idx + IW'(1);
            end
        end
    end

    assign o_valid = r_valid;
    assign o_idx   = r_idx;
    assign o_done  = r_done;

endmodule

// File: rtl/pux_mi.sv
// Command master toward pux_si: sends an opcode, optionally streams the A/B/M
// operand buffers on request, collects status (or times out) and responds.
module pux_mi #(
    parameter int OPCW    = pux_pkg::OPCW,
    parameter int DATAW   = pux_pkg::DATAW,
    parameter int STATUSW = pux_pkg::STATUSW,
    parameter int NWORDS  = pux_pkg::NWORDS,
    parameter int TIMEOUT = pux_pkg::TIMEOUT
) (
    input  logic                      axis_clk,
    input  logic                      axis_rstn,
    input  logic                      host_wr_en,
    input  logic [1:0]                host_wr_sel,
    input  logic [$clog2(NWORDS)-1:0] host_wr_addr,
    input  logic [DATAW-1:0]          host_wr_data,
    input  logic [OPCW-1:0]           cmd_opcode,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    output logic [OPCW-1:0]           axis_opcode_data,
    output logic                      axis_opcode_valid,
    input  logic                      axis_opcode_ready,
    output logic [DATAW-1:0]          axis_abuff_data,
    output logic                      axis_abuff_valid,
    input  logic                      axis_abuff_ready,
    output logic [DATAW-1:0]          axis_bbuff_data,
    output logic                      axis_bbuff_valid,
    input  logic                      axis_bbuff_ready,
    output logic [DATAW-1:0]          axis_mbuff_data,
    output logic                      axis_mbuff_valid,
    input  logic                      axis_mbuff_ready,
    input  logic                      stream_reqest,
    input  logic [STATUSW-1:0]        axis_status_data,
    input  logic                      axis_status_valid,
    output logic                      axis_status_ready,
    output logic [STATUSW-1:0]        rsp_status,
    output logic                      rsp_timeout,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      busy
);
    import pux_pkg::*;

    localparam int IW = $clog2(NWORDS);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t               r_state;
    logic [OPCW-1:0]      r_opcode;
    logic                 r_cmd_ready;
    logic                 r_op_valid;
    logic                 r_sts_ready;
    logic                 r_rsp_valid;
    logic [STATUSW-1:0]   r_rsp_status;
    logic                 r_rsp_timeout;
    logic                 r_busy;
    logic [CW-1:0]        r_cnt;

    logic [DATAW-1:0]     r_abuf [NWORDS];
    logic [DATAW-1:0]     r_bbuf [NWORDS];
    logic [DATAW-1:0]     r_mbuf [NWORDS];

    logic                 w_sts_hs;
    logic                 w_stream_start;
    logic                 w_cnt_last;
    logic [2:0]           w_done;
    logic [IW-1:0]        w_a_idx;
    logic [IW-1:0]        w_b_idx;
    logic [IW-1:0]        w_m_idx;

    // Operand store keeps its contents through reset; host writes land only while idle.
    always_ff @(posedge axis_clk) begin
        if (host_wr_en && r_state == ST_IDLE) begin
            case (host_wr_sel)
                SEL_A:   r_abuf[host_wr_addr] <= host_wr_data;
                SEL_B:   r_bbuf[host_wr_addr] <= host_wr_data;
                SEL_M:   r_mbuf[host_wr_addr] <= host_wr_data;
                default: ;
            endcase
        end
    end

    assign w_sts_hs       = axis_status_valid && r_sts_ready;
    assign w_stream_start = (r_state == ST_WAIT_RSP) && stream_reqest && !w_sts_hs;
    assign w_cnt_last     = (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge axis_clk or posedge axis_rstn) begin
        if (axis_rstn) begin
            r_state       <= ST_IDLE;
            r_opcode      <= '0;
            r_cmd_ready   <= 1'b0;
            r_op_valid    <= 1'b0;
            r_sts_ready   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_status  <= '0;
            r_rsp_timeout <= 1'b0;
            r_busy        <= 1'b0;
            r_cnt         <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (cmd_valid && r_cmd_ready) begin
                        r_opcode    <= cmd_opcode;
                        r_cmd_ready <= 1'b0;
                        r_op_valid  <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ST_SEND_OP;
                    end
                end
                ST_SEND_OP: begin
                    if (axis_opcode_ready) begin
                        r_op_valid  <= 1'b0;
                        r_sts_ready <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= ST_WAIT_RSP;
                    end
                end
                // Status beats a simultaneous stream request; timeout is checked last.
                ST_WAIT_RSP, ST_WAIT_STS: begin
                    if (w_sts_hs) begin
                        r_sts_ready   <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_status  <= axis_status_data;
                        r_rsp_timeout <= 1'b0;
                        r_state       <= ST_RESPOND;
                    end else if (w_stream_start) begin
                        r_sts_ready <= 1'b0;
                        r_state     <= ST_STREAM;
                    end else if (w_cnt_last) begin
                        r_sts_ready   <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_status  <= '0;
                        r_rsp_timeout <= 1'b1;
                        r_state       <= ST_RESPOND;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_STREAM: begin
                    if (&w_done) begin
                        r_sts_ready <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= ST_WAIT_STS;
                    end
                end
                ST_RESPOND: begin
                    if (rsp_ready) begin
                        r_rsp_valid   <= 1'b0;
                        r_rsp_status  <= '0;
                        r_rsp_timeout <= 1'b0;
                        r_busy        <= 1'b0;
                        r_cmd_ready   <= 1'b1;
                        r_state       <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    pux_mi_chan #(.NWORDS(NWORDS)) u_chan_a (
        .axis_clk  (axis_clk),
        .axis_rstn (axis_rstn),
        .i_start   (w_stream_start),
        .i_ready   (axis_abuff_ready),
        .o_valid   (axis_abuff_valid),
        .o_idx     (w_a_idx),
        .o_done    (w_done[0])
    );

    pux_mi_chan #(.NWORDS(NWORDS)) u_chan_b (
        .axis_clk  (axis_clk),
        .axis_rstn (axis_rstn),
        .i_start   (w_stream_start),
        .i_ready   (axis_bbuff_ready),
        .o_valid   (axis_bbuff_valid),
        .o_idx     (w_b_idx),
        .o_done    (w_done[1])
    );

    pux_mi_chan #(.NWORDS(NWORDS)) u_chan_m (
        .axis_clk  (axis_clk),
        .axis_rstn (axis_rstn),
        .i_start   (w_stream_start),
        .i_ready   (axis_mbuff_ready),
        .o_valid   (axis_mbuff_valid),
        .o_idx     (w_m_idx),
        .o_done    (w_done[2])
    );

    assign axis_abuff_data   = r_abuf[w_a_idx];
    assign axis_bbuff_data   = r_bbuf[w_b_idx];
    assign axis_mbuff_data   = r_mbuf[w_m_idx];
    assign cmd_ready         = r_cmd_ready;
    assign axis_opcode_data  = r_opcode;
    assign axis_opcode_valid = r_op_valid;
    assign axis_status_ready = r_sts_ready;
    assign rsp_valid         = r_rsp_valid;
    assign rsp_status        = r_rsp_status;
    assign rsp_timeout       = r_rsp_timeout;
    assign busy              = r_busy;

endmodule

// File: tb/tb_pux_mi.sv
// Directed bench for pux_mi: plays the pux_si side (opcode/operand/status) and
// the host side, one task per scenario.
module tb_pux_mi;
    import pux_pkg::*;

    logic               axis_clk = 1'b0;
    logic               axis_rstn;
    logic               host_wr_en;
    logic [1:0]         host_wr_sel;
    logic [1:0]         host_wr_addr;
    logic [DATAW-1:0]   host_wr_data;
    logic [OPCW-1:0]    cmd_opcode;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [OPCW-1:0]    axis_opcode_data;
    logic               axis_opcode_valid;
    logic               axis_opcode_ready;
    logic [DATAW-1:0]   axis_abuff_data, axis_bbuff_data, axis_mbuff_data;
    logic               axis_abuff_valid, axis_bbuff_valid, axis_mbuff_valid;
    logic               axis_abuff_ready, axis_bbuff_ready, axis_mbuff_ready;
    logic               stream_reqest;
    logic [STATUSW-1:0] axis_status_data;
    logic               axis_status_valid;
    logic               axis_status_ready;
    logic [STATUSW-1:0] rsp_status;
    logic               rsp_timeout;
    logic               rsp_valid;
    logic               rsp_ready;
    logic               busy;

    pux_mi dut (
        .axis_clk(axis_clk), .axis_rstn(axis_rstn),
        .host_wr_en(host_wr_en), .host_wr_sel(host_wr_sel),
        .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
        .cmd_opcode(cmd_opcode), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .axis_opcode_data(axis_opcode_data), .axis_opcode_valid(axis_opcode_valid),
        .axis_opcode_ready(axis_opcode_ready),
        .axis_abuff_data(axis_abuff_data), .axis_abuff_valid(axis_abuff_valid),
        .axis_abuff_ready(axis_abuff_ready),
        .axis_bbuff_data(axis_bbuff_data), .axis_bbuff_valid(axis_bbuff_valid),
        .axis_bbuff_ready(axis_bbuff_ready),
        .axis_mbuff_data(axis_mbuff_data), .axis_mbuff_valid(axis_mbuff_valid),
        .axis_mbuff_ready(axis_mbuff_ready),
        .stream_reqest(stream_reqest),
        .axis_status_data(axis_status_data), .axis_status_valid(axis_status_valid),
        .axis_status_ready(axis_status_ready),
        .rsp_status(rsp_status), .rsp_timeout(rsp_timeout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .busy(busy)
    );

    always #5 axis_clk = ~axis_clk;

    int n_run  = 0;
    int n_fail = 0;

    logic [DATAW-1:0] qs [3][$];
    logic [OPCW-1:0]  qop[$];
    int               stab_err = 0;
    logic [3:0]       pv = '0;
    logic [3:0]       pr = '0;
    logic [DATAW-1:0] pd [4];

    // Transfer log and hold-stability watch on opcode (0), A (1), B (2), M (3).
    always @(negedge axis_clk) begin
        logic [3:0]       v;
        logic [3:0]       r;
        logic [DATAW-1:0] d [4];
        v = {axis_mbuff_valid, axis_bbuff_valid, axis_abuff_valid, axis_opcode_valid};
        r = {axis_mbuff_ready, axis_bbuff_ready, axis_abuff_ready, axis_opcode_ready};
        d[0] = DATAW'(axis_opcode_data);
        d[1] = axis_abuff_data;
        d[2] = axis_bbuff_data;
        d[3] = axis_mbuff_data;
        if (!axis_rstn) begin
            for (int i = 0; i < 4; i++)
                if (pv[i] && !pr[i] && (!v[i] || d[i] !== pd[i])) stab_err++;
            if (v[0] && r[0]) qop.push_back(axis_opcode_data);
            for (int c = 0; c < 3; c++)
                if (v[c+1] && r[c+1]) qs[c].push_back(d[c+1]);
        end
        pv = axis_rstn ? 4'b0 : v;
        pr = r;
        for (int i = 0; i < 4; i++) pd[i] = d[i];
    end

    task automatic tick();
        @(posedge axis_clk);
        #1;
    endtask

    task automatic clear_logs();
        for (int c = 0; c < 3; c++) qs[c].delete();
        qop.delete();
        stab_err = 0;
    endtask

    task automatic send_cmd(input logic [OPCW-1:0] op);
        cmd_opcode = op;
        cmd_valid  = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (cmd_ready) begin
                tick();
                cmd_valid = 1'b0;
                return;
            end
            tick();
        end
        cmd_valid = 1'b0;
        n_run++; n_fail++;
        $display("FAIL cmd_accept op=%h: cmd_ready stayed 0 for 50 cycles, required 1", op);
    endtask

    task automatic wait_rsp(input int maxc, output int cyc);
        cyc = 0;
        while (!rsp_valid && cyc < maxc) begin
            tick();
            cyc++;
        end
        n_run++;
        if (rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rsp_wait: rsp_valid=%b after %0d cycles, required 1", rsp_valid, cyc);
        end
    endtask

    task automatic wait_sts_ready(input int maxc);
        int k;
        k = 0;
        while (!axis_status_ready && k < maxc) begin
            tick();
            k++;
        end
        n_run++;
        if (axis_status_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL sts_ready_wait: axis_status_ready=%b after %0d cycles, required 1", axis_status_ready, k);
        end
    endtask

    task automatic load_store();
        for (int s = 0; s < 3; s++)
            for (int i = 0; i < NWORDS; i++) begin
                host_wr_en   = 1'b1;
                host_wr_sel  = 2'(s);
                host_wr_addr = 2'(i);
                host_wr_data = DATAW'((s + 1) * 32'h1000 + i);
                tick();
            end
        host_wr_en = 1'b0;
    endtask

    task automatic test_reset();
        axis_rstn = 1'b0;
        #2 axis_rstn = 1'b1;
        tick(); tick();
        n_run++;
        if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_ready: got %b, required 0", cmd_ready); end
        n_run++;
        if ({axis_opcode_valid, axis_abuff_valid, axis_bbuff_valid, axis_mbuff_valid, rsp_valid} !== 5'b0) begin
            n_fail++;
            $display("FAIL rst_valids: got %b, required 00000",
                     {axis_opcode_valid, axis_abuff_valid, axis_bbuff_valid, axis_mbuff_valid, rsp_valid});
        end
        n_run++;
        if ({axis_status_ready, busy, rsp_timeout, rsp_status} !== 5'b0) begin
            n_fail++;
            $display("FAIL rst_misc: got %b, required 00000", {axis_status_ready, busy, rsp_timeout, rsp_status});
        end
        axis_rstn = 1'b0;
        tick();
        n_run++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_cmd_ready: got %b, required 1", cmd_ready); end
    endtask

    task automatic test_basic();
        clear_logs();
        send_cmd(8'h17);
        n_run++;
        if (axis_opcode_valid !== 1'b1 || axis_opcode_data !== 8'h17) begin
            n_fail++;
            $display("FAIL basic_opcode_out: valid=%b data=%h, required 1/17", axis_opcode_valid, axis_opcode_data);
        end
        tick();
        n_run++;
        if (axis_status_ready !== 1'b1) begin n_fail++; $display("FAIL basic_sts_ready: got %b, required 1", axis_status_ready); end
        tick(); tick();
        axis_status_data  = 2'd3;
        axis_status_valid = 1'b1;
        tick();
        axis_status_valid = 1'b0;
        n_run++;
        if ({rsp_valid, rsp_status, rsp_timeout} !== {1'b1, 2'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_rsp: valid/status/timeout=%b/%0d/%b, required 1/3/0", rsp_valid, rsp_status, rsp_timeout);
        end
        n_run++;
        if (qop.size() !== 1 || qop[0] !== 8'h17) begin
            n_fail++;
            $display("FAIL basic_opcode_count: %0d opcodes, first %h, required 1 of 17", qop.size(), qop.size() ? qop[0] : 8'h0);
        end
        n_run++;
        if (qs[0].size() + qs[1].size() + qs[2].size() !== 0) begin
            n_fail++;
            $display("FAIL basic_no_stream: %0d words, required 0", qs[0].size() + qs[1].size() + qs[2].size());
        end
        tick();
    endtask

    task automatic test_latency();
        int cyc;
        axis_status_data  = 2'd1;
        axis_status_valid = 1'b1;
        send_cmd(8'h05);
        n_run++;
        if (axis_status_ready !== 1'b0) begin n_fail++; $display("FAIL lat_sts_gate: status_ready=%b in SEND_OP, required 0", axis_status_ready); end
        wait_rsp(10, cyc);
        axis_status_valid = 1'b0;
        n_run++;
        if (cyc + 1 !== 3) begin n_fail++; $display("FAIL lat_cycles: got %0d, required 3", cyc + 1); end
        n_run++;
        if (rsp_status !== 2'd1) begin n_fail++; $display("FAIL lat_status: got %0d, required 1", rsp_status); end
        tick();
        n_run++;
        if ({busy, cmd_ready, rsp_valid} !== 3'b010) begin
            n_fail++;
            $display("FAIL lat_back_idle: busy/cmd_ready/rsp_valid=%b, required 010", {busy, cmd_ready, rsp_valid});
        end
    endtask

    task automatic test_stream();
        clear_logs();
        send_cmd(8'h02);
        host_wr_en   = 1'b1;
        host_wr_sel  = SEL_A;
        host_wr_addr = 2'd0;
        host_wr_data = 16'hDEAD;
        tick();
        host_wr_en    = 1'b0;
        stream_reqest = 1'b1;
        tick();
        n_run++;
        if (axis_status_ready !== 1'b0 || axis_abuff_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stream_entry: status_ready=%b abuff_valid=%b, required 0/1", axis_status_ready, axis_abuff_valid);
        end
        wait_sts_ready(40);
        stream_reqest     = 1'b0;
        axis_status_data  = 2'd0;
        axis_status_valid = 1'b1;
        tick();
        axis_status_valid = 1'b0;
        n_run++;
        if ({rsp_valid, rsp_status, rsp_timeout} !== {1'b1, 2'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL stream_rsp: valid/status/timeout=%b/%0d/%b, required 1/0/0", rsp_valid, rsp_status, rsp_timeout);
        end
        for (int c = 0; c < 3; c++) begin
            n_run++;
            if (qs[c].size() !== NWORDS) begin n_fail++; $display("FAIL stream_count ch%0d: got %0d words, required %0d", c, qs[c].size(), NWORDS); end
            for (int i = 0; i < NWORDS && i < qs[c].size(); i++) begin
                n_run++;
                if (qs[c][i] !== DATAW'((c + 1) * 32'h1000 + i)) begin
                    n_fail++;
                    $display("FAIL stream_word ch%0d[%0d]: got %h, required %h", c, i, qs[c][i], DATAW'((c + 1) * 32'h1000 + i));
                end
            end
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [15:0] pat;
        pat = 16'b1011_0010_0110_1001;
        clear_logs();
        axis_opcode_ready = 1'b0;
        send_cmd(8'h2A);
        repeat (5) tick();
        n_run++;
        if (axis_opcode_valid !== 1'b1 || axis_opcode_data !== 8'h2A) begin
            n_fail++;
            $display("FAIL bp_opcode_hold: valid=%b data=%h, required 1/2A", axis_opcode_valid, axis_opcode_data);
        end
        axis_opcode_ready = 1'b1;
        tick();
        stream_reqest = 1'b1;
        tick();
        stream_reqest = 1'b0;
        for (int k = 0; k < 80 && !axis_status_ready; k++) begin
            axis_bbuff_ready = pat[k % 16];
            tick();
        end
        axis_bbuff_ready = 1'b1;
        wait_sts_ready(1);
        axis_status_data  = 2'd2;
        axis_status_valid = 1'b1;
        tick();
        axis_status_valid = 1'b0;
        n_run++;
        if (rsp_valid !== 1'b1 || rsp_status !== 2'd2) begin
            n_fail++;
            $display("FAIL bp_rsp: valid/status=%b/%0d, required 1/2", rsp_valid, rsp_status);
        end
        n_run++;
        if (stab_err !== 0) begin n_fail++; $display("FAIL bp_stability: %0d unstable holds, required 0", stab_err); end
        n_run++;
        if (qop.size() !== 1) begin n_fail++; $display("FAIL bp_opcode_count: got %0d, required 1", qop.size()); end
        for (int c = 0; c < 3; c++) begin
            n_run++;
            if (qs[c].size() !== NWORDS) begin n_fail++; $display("FAIL bp_count ch%0d: got %0d words, required %0d", c, qs[c].size(), NWORDS); end
            for (int i = 0; i < NWORDS && i < qs[c].size(); i++) begin
                n_run++;
                if (qs[c][i] !== DATAW'((c + 1) * 32'h1000 + i)) begin
                    n_fail++;
                    $display("FAIL bp_word ch%0d[%0d]: got %h, required %h", c, i, qs[c][i], DATAW'((c + 1) * 32'h1000 + i));
                end
            end
        end
        tick();
    endtask

    task automatic test_timeout();
        int cyc;
        send_cmd(8'h44);
        tick();
        n_run++;
        if (axis_status_ready !== 1'b1) begin n_fail++; $display("FAIL to_entry: status_ready=%b, required 1", axis_status_ready); end
        wait_rsp(300, cyc);
        n_run++;
        if (cyc !== TIMEOUT) begin n_fail++; $display("FAIL to_cycles: got %0d, required %0d", cyc, TIMEOUT); end
        n_run++;
        if (rsp_timeout !== 1'b1 || rsp_status !== 2'd0) begin
            n_fail++;
            $display("FAIL to_rsp: timeout/status=%b/%0d, required 1/0", rsp_timeout, rsp_status);
        end
        tick();
    endtask

    task automatic test_rsp_hold();
        int cyc;
        rsp_ready         = 1'b0;
        axis_status_data  = 2'd1;
        axis_status_valid = 1'b1;
        send_cmd(8'h33);
        wait_rsp(10, cyc);
        axis_status_valid = 1'b0;
        repeat (3) tick();
        n_run++;
        if ({rsp_valid, rsp_status, cmd_ready, busy} !== {1'b1, 2'd1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL hold_rsp: valid/status/cmd_ready/busy=%b/%0d/%b/%b, required 1/1/0/1", rsp_valid, rsp_status, cmd_ready, busy);
        end
        rsp_ready = 1'b1;
        tick();
        n_run++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_release: rsp_valid/cmd_ready=%b/%b, required 0/1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_reset_mid();
        axis_bbuff_ready = 1'b0;
        axis_mbuff_ready = 1'b0;
        clear_logs();
        send_cmd(8'h2B);
        tick();
        stream_reqest = 1'b1;
        tick();
        stream_reqest = 1'b0;
        tick(); tick();
        axis_rstn = 1'b1;
        #1;
        n_run++;
        if ({axis_opcode_valid, axis_abuff_valid, axis_bbuff_valid, axis_mbuff_valid, rsp_valid, axis_status_ready, busy} !== 7'b0) begin
            n_fail++;
            $display("FAIL mid_rst_outputs: got %b, required 0000000",
                     {axis_opcode_valid, axis_abuff_valid, axis_bbuff_valid, axis_mbuff_valid, rsp_valid, axis_status_ready, busy});
        end
        n_run++;
        if (qs[0].size() !== 2) begin n_fail++; $display("FAIL mid_rst_pre_words: got %0d, required 2", qs[0].size()); end
        tick();
        axis_rstn = 1'b0;
        tick();
        axis_bbuff_ready = 1'b1;
        axis_mbuff_ready = 1'b1;
        clear_logs();
        send_cmd(8'h1F);
        tick();
        stream_reqest = 1'b1;
        tick();
        stream_reqest = 1'b0;
        wait_sts_ready(40);
        axis_status_data  = 2'd0;
        axis_status_valid = 1'b1;
        tick();
        axis_status_valid = 1'b0;
        n_run++;
        if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL mid_rsp: rsp_valid=%b, required 1", rsp_valid); end
        n_run++;
        if (qop.size() !== 1 || qop[0] !== 8'h1F) begin
            n_fail++;
            $display("FAIL mid_opcode: %0d opcodes, first %h, required 1 of 1F", qop.size(), qop.size() ? qop[0] : 8'h0);
        end
        n_run++;
        if (qs[0].size() !== NWORDS) begin n_fail++; $display("FAIL mid_count: got %0d, required %0d", qs[0].size(), NWORDS); end
        for (int i = 0; i < NWORDS && i < qs[0].size(); i++) begin
            n_run++;
            if (qs[0][i] !== DATAW'(32'h1000 + i)) begin
                n_fail++;
                $display("FAIL mid_word a[%0d]: got %h, required %h", i, qs[0][i], DATAW'(32'h1000 + i));
            end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [OPCW-1:0]    ops [6];
        logic [STATUSW-1:0] sts [6];
        int cyc;
        ops = '{8'h23, 8'h02, 8'h31, 8'h17, 8'h12, 8'h01};
        sts = '{2'd3, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0};
        clear_logs();
        for (int k = 0; k < 6; k++) begin
            axis_status_data  = sts[k];
            axis_status_valid = 1'b1;
            send_cmd(ops[k]);
            wait_rsp(20, cyc);
            axis_status_valid = 1'b0;
            n_run++;
            if (rsp_status !== sts[k] || rsp_timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_status[%0d]: status/timeout=%0d/%b, required %0d/0", k, rsp_status, rsp_timeout, sts[k]);
            end
            tick();
        end
        n_run++;
        if (qop.size() !== 6) begin n_fail++; $display("FAIL b2b_opcode_count: got %0d, required 6", qop.size()); end
        for (int k = 0; k < 6 && k < qop.size(); k++) begin
            n_run++;
            if (qop[k] !== ops[k]) begin n_fail++; $display("FAIL b2b_opcode[%0d]: got %h, required %h", k, qop[k], ops[k]); end
        end
    endtask

    initial begin
        host_wr_en = 0; host_wr_sel = 0; host_wr_addr = 0; host_wr_data = 0;
        cmd_opcode = 0; cmd_valid = 0;
        axis_opcode_ready = 1; axis_abuff_ready = 1; axis_bbuff_ready = 1; axis_mbuff_ready = 1;
        stream_reqest = 0; axis_status_data = 0; axis_status_valid = 0; rsp_ready = 1;
        test_reset();
        load_store();
        test_basic();
        test_latency();
        test_stream();
        test_backpressure();
        test_timeout();
        test_rsp_hold();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pux_mi.md
PUX_MI -- requirements
Module: pux_mi

Interface
REQ-001 Parameters: OPCW 8 opcode width; DATAW 16 operand word width; STATUSW 2 status width; NWORDS 4 words per operand buffer; TIMEOUT 200 response-wait cycles.
REQ-002 axis_clk  in  1  clock; all logic on rising edge.
REQ-003 axis_rstn  in  1  reset, asynchronous, active-high.
REQ-004 host_wr_en / host_wr_sel / host_wr_addr / host_wr_data  in  1 / 2 / log2(NWORDS) / DATAW  operand store write port; sel 0=A, 1=B, 2=M, 3 ignored.
REQ-005 cmd_opcode / cmd_valid / cmd_ready  in / in / out  OPCW / 1 / 1  host command stream.
REQ-006 axis_opcode_data / axis_opcode_valid / axis_opcode_ready  out / out / in  OPCW / 1 / 1  opcode master toward pux_si.
REQ-007 axis_{a,b,m}buff_data / _valid / _ready  out / out / in  DATAW / 1 / 1  three operand masters.
REQ-008 stream_reqest  in  1  operand fetch request from pux_si.
REQ-009 axis_status_data / axis_status_valid / axis_status_ready  in / in / out  STATUSW / 1 / 1  status slave.
REQ-010 rsp_status / rsp_timeout / rsp_valid / rsp_ready  out / out / out / in  STATUSW / 1 / 1 / 1  host response.
REQ-011 busy  out  1  high whenever FSM not IDLE.

Function
REQ-012 Operand store: 3 x NWORDS x DATAW registers; writes accepted only in IDLE, otherwise dropped; not cleared by reset.
REQ-013 FSM states: IDLE, SEND_OP, WAIT_RSP, STREAM, WAIT_STS, RESPOND.
REQ-014 IDLE: cmd_ready=1; on cmd_valid capture opcode -> SEND_OP next cycle.
REQ-015 SEND_OP: axis_opcode_valid=1, data stable until axis_opcode_ready sampled high; then -> WAIT_RSP, valid deasserted next cycle.
REQ-016 WAIT_RSP: axis_status_ready=1; status handshake -> capture status, RESPOND; else stream_reqest=1 -> STREAM; status takes priority when both occur same cycle.
REQ-017 STREAM: each channel drives word 0..NWORDS-1 in order, valid held until its own ready; channels advance independently; axis_status_ready=0.
REQ-018 STREAM exit: when all three channels have transferred NWORDS words -> WAIT_STS; stream_reqest ignored while in STREAM.
REQ-019 WAIT_STS: axis_status_ready=1; status handshake -> capture, RESPOND.
REQ-020 Timeout: cycle counter cleared on entry to WAIT_RSP/WAIT_STS, counts only there; reaching TIMEOUT -> RESPOND with rsp_timeout=1, rsp_status=0.
REQ-021 STREAM has no timeout.
REQ-022 RESPOND: rsp_valid=1, outputs stable until rsp_ready; then -> IDLE; cmd_ready=0 until IDLE.
REQ-023 Minimum command latency, all readies high, no stream: cmd accept to rsp_valid = 3 cycles.
REQ-024 Status arriving outside WAIT_RSP/WAIT_STS is not accepted (ready low).

Reset
REQ-025 On axis_rstn high: FSM IDLE; all valid outputs 0; axis_status_ready 0; cmd_ready 0 while reset held, 1 first cycle after release; rsp_* 0; busy 0; counters 0.
REQ-026 Reset mid-operation aborts immediately; no partial-transfer resume; next command starts at word 0.

Structure
REQ-027 Shared package pux_pkg: OPCW, DATAW, STATUSW, NWORDS, TIMEOUT, FSM state encoding, buffer select codes.
REQ-028 Sub-module pux_mi_chan: one operand streamer (word index counter, valid/ready, done flag), instantiated three times.

Verification
REQ-029 Store A/B/M = 0x1000+i/0x2000+i/0x3000+i, cmd 0x17, no stream, status 3 after 2 cycles -> opcode 0x17 seen once, rsp_status=3, rsp_timeout=0.
REQ-030 Cmd 0x02, stream_reqest pulse after opcode accept -> exactly 4 words per channel in order 0x1000..0x1003 etc., then status 0 accepted, rsp_status=0.
REQ-031 Random ready backpressure on bbuff (50%) and opcode ready delayed 5 cycles -> data/valid held stable, no word lost or duplicated.
REQ-032 No status ever returned -> rsp_valid with rsp_timeout=1 exactly 200 cycles after WAIT_RSP entry.
REQ-033 Reset asserted after 2 abuff words -> all valids 0 immediately; new cmd 0x1F restarts at word 0x1000.
REQ-034 Six back-to-back cmds 23,02,31,17,12,01 with rsp_ready tied high -> six responses in order, statuses 3,0,1,0,0,0.
